// File: rtl/exmem_skid_reg.sv
// EX/MEM stage register with valid/ready handshake and a two-entry skid buffer; one-cycle latency.
// in_ready_o depends only on registered state plus start/flush, so back-pressure never forms a combinational path.
module exmem_skid_reg #(
  parameter int DATA_W = 69,
  parameter int CTRL_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FULL  = 2'd1,
    S_SKID  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic run;
  logic accept;
  logic pop;

  assign run         = start_i && !flush_i;
  assign in_ready_o  = run && (state_q != S_SKID);
  assign out_valid_o = run && (state_q != S_EMPTY);
  assign accept      = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    // Flush clears only the valid state; payload registers keep their contents.
    if (flush_i) begin
      state_d = S_EMPTY;
    end else if (start_i) begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            state_d     = S_FULL;
            main_data_d = data_i;
            main_ctrl_d = ctrl_i;
          end
        end
        S_FULL: begin
          if (accept && pop) begin
            main_data_d = data_i;
            main_ctrl_d = ctrl_i;
          end else if (accept) begin
            state_d     = S_SKID;
            skid_data_d = data_i;
            skid_ctrl_d = ctrl_i;
          end else if (pop) begin
            state_d = S_EMPTY;
          end
        end
        S_SKID: begin
          if (pop) begin
            state_d     = S_FULL;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid_o && !out_ready_i && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign data_o      = main_data_q;
  assign ctrl_o      = out_valid_o ? main_ctrl_q : '0;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_exmem_skid_reg.sv
// Directed bench for exmem_skid_reg: streaming, skid fill, flush, start gating, reset and counter saturation.
module tb_exmem_skid_reg;

  localparam int DATA_W = 69;
  localparam int CTRL_W = 4;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              start_i;
  logic              flush_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] data_i;
  logic [CTRL_W-1:0] ctrl_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] data_o;
  logic [CTRL_W-1:0] ctrl_o;
  logic [15:0]       stall_cnt_o;

  logic              s_in_valid;
  logic              s_in_ready;
  logic [DATA_W-1:0] s_data_i;
  logic [CTRL_W-1:0] s_ctrl_i;
  logic              s_out_valid;
  logic              s_out_ready;
  logic [DATA_W-1:0] s_data_o;
  logic [CTRL_W-1:0] s_ctrl_o;
  logic [3:0]        s_stall_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  exmem_skid_reg dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .data_i(data_i), .ctrl_i(ctrl_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .data_o(data_o), .ctrl_o(ctrl_o),
    .stall_cnt_o(stall_cnt_o)
  );

  exmem_skid_reg #(.CNT_W(4)) dut_sat (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .flush_i(1'b0),
    .in_valid_i(s_in_valid), .in_ready_o(s_in_ready), .data_i(s_data_i), .ctrl_i(s_ctrl_i),
    .out_valid_o(s_out_valid), .out_ready_i(s_out_ready), .data_o(s_data_o), .ctrl_o(s_ctrl_o),
    .stall_cnt_o(s_stall_cnt)
  );

  task automatic chk(input string tag, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Advance one clock edge and land on the following falling edge.
  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic present(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                         input logic rdy);
    in_valid_i  = v;
    data_i      = d;
    ctrl_i      = c;
    out_ready_i = rdy;
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b1; flush_i = 1'b0;
    present(1'b0, '0, '0, 1'b0);
    s_in_valid = 1'b0; s_data_i = '0; s_ctrl_i = '0; s_out_ready = 1'b1;

    @(negedge clk_i);
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_in_ready", in_ready_o, 1);
    chk("rst_data", data_o, 0);
    chk("rst_ctrl", ctrl_o, 0);
    chk("rst_stall", stall_cnt_o, 0);
    chk("rst_sat_in_ready", s_in_ready, 1);
    rst_i = 1'b0;

    // Streaming A,B,C with downstream always ready
    present(1'b1, 69'h1, 4'b1010, 1'b1);
    tick();
    chk("stream_A_valid", out_valid_o, 1);
    chk("stream_A_data", data_o, 69'h1);
    chk("stream_A_ctrl", ctrl_o, 4'b1010);
    present(1'b1, 69'h2, 4'b1010, 1'b1);
    chk("stream_ready_B", in_ready_o, 1);
    tick();
    chk("stream_B_data", data_o, 69'h2);
    present(1'b1, 69'h3, 4'b1010, 1'b1);
    chk("stream_ready_C", in_ready_o, 1);
    tick();
    chk("stream_C_data", data_o, 69'h3);
    chk("stream_C_valid", out_valid_o, 1);
    present(1'b0, '0, '0, 1'b1);
    tick();
    chk("stream_drain_valid", out_valid_o, 0);
    chk("stream_drain_ctrl", ctrl_o, 0);
    chk("stream_stall", stall_cnt_o, 0);

    // Skid fill: A accepted, then three back-pressured cycles
    present(1'b1, 69'h11, 4'b0110, 1'b1);
    tick();
    present(1'b1, 69'h12, 4'b0110, 1'b0);
    chk("skid_ready_B", in_ready_o, 1);
    tick();
    present(1'b1, 69'h13, 4'b0110, 1'b0);
    chk("skid_refuse_C1", in_ready_o, 0);
    chk("skid_hold_A1", data_o, 69'h11);
    tick();
    chk("skid_refuse_C2", in_ready_o, 0);
    tick();
    chk("skid_hold_A3", data_o, 69'h11);
    chk("skid_valid", out_valid_o, 1);
    chk("skid_stall3", stall_cnt_o, 3);
    chk("skid_ctrl", ctrl_o, 4'b0110);
    out_ready_i = 1'b1;
    chk("skid_still_refuse", in_ready_o, 0);
    tick();
    chk("skid_out_B", data_o, 69'h12);
    chk("skid_ready_back", in_ready_o, 1);
    tick();
    chk("skid_out_C", data_o, 69'h13);
    chk("skid_out_C_valid", out_valid_o, 1);
    present(1'b0, '0, '0, 1'b1);
    tick();
    chk("skid_drain", out_valid_o, 0);
    chk("skid_stall_kept", stall_cnt_o, 3);

    // Flush while in SKID with a new entry presented
    present(1'b1, 69'h21, 4'b1100, 1'b1);
    tick();
    present(1'b1, 69'h22, 4'b1100, 1'b0);
    tick();
    present(1'b1, 69'h23, 4'b1100, 1'b0);
    flush_i = 1'b1;
    #1;
    chk("flush_out_valid", out_valid_o, 0);
    chk("flush_in_ready", in_ready_o, 0);
    chk("flush_ctrl", ctrl_o, 0);
    tick();
    flush_i = 1'b0;
    present(1'b0, '0, '0, 1'b1);
    #1;
    chk("post_flush_valid", out_valid_o, 0);
    chk("post_flush_ctrl", ctrl_o, 0);
    chk("post_flush_ready", in_ready_o, 1);
    chk("post_flush_data_kept", data_o, 69'h21);
    chk("post_flush_stall", stall_cnt_o, 4);
    tick();
    chk("flushed_never_out", out_valid_o, 0);

    // start_i low while FULL freezes everything
    present(1'b1, 69'h31, 4'b1111, 1'b1);
    tick();
    start_i = 1'b0;
    present(1'b1, 69'h32, 4'b1111, 1'b1);
    #1;
    chk("nostart_valid", out_valid_o, 0);
    chk("nostart_ready", in_ready_o, 0);
    chk("nostart_ctrl", ctrl_o, 0);
    tick();
    chk("nostart_hold_data", data_o, 69'h31);
    chk("nostart_stall", stall_cnt_o, 4);
    start_i = 1'b1;
    present(1'b0, '0, '0, 1'b1);
    #1;
    chk("restart_valid", out_valid_o, 1);
    chk("restart_data", data_o, 69'h31);
    chk("restart_ctrl", ctrl_o, 4'b1111);
    tick();
    chk("restart_popped", out_valid_o, 0);

    // Counter saturation on the CNT_W=4 instance
    s_in_valid = 1'b1; s_data_i = 69'h7; s_ctrl_i = 4'b0011;
    tick();
    s_in_valid = 1'b0; s_out_ready = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("sat_cnt10", s_stall_cnt, 10);
    for (int i = 0; i < 10; i++) tick();
    chk("sat_cnt15", s_stall_cnt, 15);
    chk("sat_hold_data", s_data_o, 69'h7);
    chk("sat_hold_ctrl", s_ctrl_o, 4'b0011);
    chk("sat_valid", s_out_valid, 1);

    // Asynchronous reset mid-cycle while FULL
    present(1'b1, 69'h41, 4'b1010, 1'b1);
    tick();
    present(1'b0, '0, '0, 1'b0);
    tick();
    chk("pre_rst_stall", stall_cnt_o, 5);
    #2;
    rst_i = 1'b1;
    #1;
    chk("arst_valid", out_valid_o, 0);
    chk("arst_ctrl", ctrl_o, 0);
    chk("arst_data", data_o, 0);
    chk("arst_stall", stall_cnt_o, 0);
    chk("arst_ready", in_ready_o, 1);
    chk("arst_sat_stall", s_stall_cnt, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    present(1'b1, 69'h51, 4'b0101, 1'b1);
    tick();
    chk("post_rst_valid", out_valid_o, 1);
    chk("post_rst_data", data_o, 69'h51);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exmem_skid_reg.md
# exmem_skid_reg

Parametrised EX/MEM pipeline stage register with a valid/ready handshake and a two-entry skid buffer. It sits between the execute stage and the data-memory stage. It carries a data bundle (ALU result, store data, destination register) and a control bundle (RegWrite, MemtoReg, MemRead, MemWrite). Compared with a plain enable-gated latch it adds back-pressure, synchronous flush with bubble insertion, and a saturating stall counter.

## Interface
- DATA_W, 69: data bundle width (32 ALU result + 32 store data + 5 rd address).
- CTRL_W, 4: control bundle width. Control bits are forced to 0 whenever no valid entry is presented.
- CNT_W, 16: stall counter width.

- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  global run enable. Low freezes the block.
- flush_i  in  1  synchronous flush, discards all held entries.
- in_valid_i  in  1  upstream entry valid.
- in_ready_o  out  1  block can accept an entry this cycle.
- data_i  in  DATA_W  upstream data bundle.
- ctrl_i  in  CTRL_W  upstream control bundle.
- out_valid_o  out  1  output entry valid.
- out_ready_i  in  1  downstream accepts the output entry this cycle.
- data_o  out  DATA_W  output data bundle.
- ctrl_o  out  CTRL_W  output control bundle, all 0 when out_valid_o=0.
- stall_cnt_o  out  CNT_W  saturating count of back-pressured cycles.

## Operation
- Storage: a main register (drives the outputs) and a skid register. Each holds a data and control pair.
- States:
  - EMPTY: no entries held.
  - FULL: main register valid.
  - SKID: main and skid registers both valid.
- Handshakes:
  - Accept = in_valid_i && in_ready_o.
  - Pop = out_valid_o && out_ready_i.
- in_ready_o = start_i && !flush_i && (state != SKID). It is a function of registered state plus these two gates only, with no combinational path from out_ready_i.
- out_valid_o = start_i && !flush_i && (state != EMPTY).
- Transitions when start_i=1 and flush_i=0:
  - EMPTY: accept -> FULL, main <= input. Otherwise stay.
  - FULL, accept and pop -> FULL, main <= input.
  - FULL, accept only -> SKID, skid <= input.
  - FULL, pop only -> EMPTY.
  - FULL, neither -> stay.
  - SKID: pop -> FULL, main <= skid. Otherwise stay (no accept possible).
- flush_i=1 (priority over everything except rst_i): next state EMPTY.
  - No accept or pop occurs in that cycle.
  - Data registers keep their contents. Only the valid state clears.
- start_i=0 with flush_i=0: state, data registers and stall counter all hold. No transfers occur.
- Outputs:
  - data_o = main data register, always, even when invalid.
  - ctrl_o = main control register when out_valid_o=1, else 0.
- stall_cnt_o increments by 1 on every cycle with out_valid_o=1 and out_ready_i=0. It saturates at 2^CNT_W−1 and clears only on rst_i.
- Ordering: entries leave in exactly the order accepted. No entry is duplicated or dropped except by flush.

## Timing
- Reset values (all asynchronous on rst_i):
  - state EMPTY; main and skid data and control registers 0; stall_cnt_o 0.
  - Hence out_valid_o=0, ctrl_o=0, data_o=0. in_ready_o=start_i.
- Latency: an entry accepted at edge N is on data_o/ctrl_o with out_valid_o=1 after edge N (one cycle).
- Throughput: one entry per cycle while out_ready_i=1.
- The skid entry allows out_ready_i to drop for one cycle without losing the entry accepted in that cycle. in_ready_o falls the cycle after entry to SKID.
- Recovery from SKID: the first pop returns to FULL. in_ready_o rises in the following cycle.
- Reset mid-operation: all entries are lost immediately (asynchronous). The first accept is possible in the first cycle after rst_i deasserts, provided start_i=1.
- Flush: in the flush cycle itself, out_valid_o=0 and in_ready_o=0. In the next cycle, in_ready_o=1 if start_i=1.

## Test plan
- Reset and idle: assert rst_i mid-cycle while FULL. Required: out_valid_o, ctrl_o, data_o and stall_cnt_o read 0 immediately; in_ready_o=1 with start_i=1.
- Streaming: send entries A, B, C (data 0x1, 0x2, 0x3, ctrl 4'b1010) on consecutive cycles with out_ready_i=1. Required: outputs A, B, C on the next three cycles, in_ready_o stays 1, stall_cnt_o=0.
- Skid fill:
  - Stimulus: accept A, then drop out_ready_i for 3 cycles while in_valid_i=1 with B and C.
  - Required: B is captured into the skid register and C is refused (in_ready_o=0). A is held for 3 cycles and stall_cnt_o=3.
  - Then raise out_ready_i. Required: A, B, C are output in order.
- Flush while in SKID with in_valid_i=1: required out_valid_o=0 and in_ready_o=0 that cycle; next cycle state is EMPTY and ctrl_o=0; the presented entry never appears on the output.
- start_i=0 while FULL with out_ready_i=1: required out_valid_o=0, no pop, stall_cnt_o unchanged. Re-raising start_i re-presents the same entry.
- Saturation: with CNT_W=4, back-pressure for 20 cycles. Required: stall_cnt_o stops at 15.
